// File: rtl/cchw_pkg.sv
// Shared note-source types for the chromatic LED pipeline.
// The amplitude is a W.D unsigned fixed-point value with W=6, D=10.
package CCHW;

    localparam int AMP_W = 16;
    localparam int POS_W = 8;

    typedef struct packed {
        logic [AMP_W-1:0] amplitude;
        logic [POS_W-1:0] position;
        logic             valid;
    } Note;

endpackage

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider that returns only the QW-bit quotient.
// Callers guarantee num < den * 2**QW, so only the low QW numerator bits need shifting.
module restoring_divider #(
    parameter int NUM_W = 22,
    parameter int DEN_W = 20,
    parameter int QW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [NUM_W-1:0] i_num,
    input  logic [DEN_W-1:0] i_den,
    output logic             o_done,
    output logic [QW-1:0]    o_quot
);

    localparam int CW = (QW > 1) ? $clog2(QW) : 1;

    logic [DEN_W-1:0] r_rem;
    logic [DEN_W-1:0] r_den;
    logic [QW-1:0]    r_low;
    logic [QW-1:0]    r_q;
    logic [CW-1:0]    r_iter;
    logic             r_run;

    logic [DEN_W:0]   w_trial;
    logic             w_qbit;
    logic [DEN_W-1:0] w_rem_next;

    // A clear MSB in the trial means the shifted remainder covered the divisor.
    assign w_trial    = {r_rem, r_low[QW-1]} - {1'b0, r_den};
    assign w_qbit     = ~w_trial[DEN_W];
    assign w_rem_next = w_qbit ? w_trial[DEN_W-1:0] : {r_rem[DEN_W-2:0], r_low[QW-1]};

    // The final quotient bit is presented combinationally so the caller stores it on the last iteration edge.
    assign o_done = r_run && (r_iter == CW'(QW - 1));
    assign o_quot = {r_q[QW-2:0], w_qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_den  <= '0;
            r_low  <= '0;
            r_q    <= '0;
            r_iter <= '0;
            r_run  <= 1'b0;
        end else if (i_load) begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values, whatever the statement order.
            r_rem  <= DEN_W'(i_num[NUM_W-1:QW]);
            r_den  <= i_den;
            r_low  <= i_num[QW-1:0];
            r_q    <= '0;
            r_iter <= '0;
            r_run  <= 1'b1;
        end else if (r_run) begin
            r_rem  <= w_rem_next;
            r_low  <= r_low << 1;
            r_q    <= {r_q[QW-2:0], w_qbit};
            r_iter <= r_iter + CW'(1);
            if (o_done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/led_count_allocator.sv
// Splits LEDS across BIN_QTY note bins in proportion to amplitude; the rounding
// remainder goes to the loudest bin so every published frame sums to exactly LEDS.
module led_count_allocator
    import CCHW::*;
#(
    parameter int W       = 6,
    parameter int D       = 10,
    parameter int LEDS    = 50,
    parameter int BIN_QTY = 12
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  Note [BIN_QTY-1:0]                    notes,
    input  logic                                 start,
    output logic [BIN_QTY-1:0][$clog2(LEDS)-1:0] LEDCounts,
    output logic                                 data_v,
    output logic                                 busy
);

    localparam int AW = W + D;
    localparam int QW = $clog2(LEDS);
    localparam int SW = AW + $clog2(BIN_QTY);
    localparam int NW = AW + QW;
    localparam int IW = $clog2(BIN_QTY + 1);

    localparam logic [IW-1:0] LAST_BIN = IW'(BIN_QTY - 1);
    localparam logic [IW-1:0] SUM_DONE = IW'(BIN_QTY);

    // A power-of-two LEDS would let a single bin's quotient reach 2**QW and overflow.
    if ((LEDS & (LEDS - 1)) == 0) begin : g_bad_leds
        $error("led_count_allocator: LEDS must not be a power of two");
    end
    if (AW != AMP_W) begin : g_bad_amp_width
        $error("led_count_allocator: W+D must match the Note amplitude width");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUM,
        S_DIV,
        S_FIXUP
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;

    logic [BIN_QTY-1:0][AW-1:0] r_amp;
    logic [BIN_QTY-1:0][QW-1:0] r_cnt;
    logic [BIN_QTY-1:0][QW-1:0] w_final;
    logic [SW-1:0]              r_sum;
    logic [QW-1:0]              r_alloc;
    logic [IW-1:0]              r_idx;
    logic [IW-1:0]              r_max_idx;
    logic                       r_load_pend;

    logic [IW-1:0]              w_div_idx;
    logic [NW-1:0]              w_num;
    logic                       w_div_load;
    logic                       w_div_done;
    logic [QW-1:0]              w_quot;
    logic                       w_unused_position;

    always_comb begin
        w_unused_position = 1'b0;
        for (int i = 0; i < BIN_QTY; i++) begin
            w_unused_position = w_unused_position ^ (^notes[i].position);
        end
    end

    // Bin 0 is loaded on the SUM decision edge; later bins load the cycle after the previous store.
    assign w_div_idx  = (r_state == S_SUM) ? '0 : r_idx;
    assign w_num      = NW'(r_amp[w_div_idx]) * NW'(LEDS);
    assign w_div_load = ((r_state == S_SUM) && (r_idx == SUM_DONE) && (r_sum != '0))
                     || ((r_state == S_DIV) && r_load_pend);

    restoring_divider #(
        .NUM_W (NW),
        .DEN_W (SW),
        .QW    (QW)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst),
        .i_load (w_div_load),
        .i_num  (w_num),
        .i_den  (r_sum),
        .o_done (w_div_done),
        .o_quot (w_quot)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: the default first means every path assigns, so no latch is inferred.
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next_state = S_SUM;
            S_SUM:   if (r_idx == SUM_DONE) w_next_state = (r_sum != '0) ? S_DIV : S_FIXUP;
            S_DIV:   if (w_div_done && (r_idx == LAST_BIN)) w_next_state = S_FIXUP;
            S_FIXUP: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
    end

    always_comb begin
        w_final = r_cnt;
        if (r_sum != '0) begin
            w_final[r_max_idx] = r_cnt[r_max_idx] + (QW'(LEDS) - r_alloc);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the amplitude and count arrays are flops, not RAM, so they are cleared by reset like any other state.
            r_amp       <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_alloc     <= '0;
            r_idx       <= '0;
            r_max_idx   <= '0;
            r_load_pend <= 1'b0;
            LEDCounts   <= '0;
            data_v      <= 1'b0;
        end else begin
            data_v      <= 1'b0;
            r_load_pend <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < BIN_QTY; i++) begin
                            r_amp[i] <= notes[i].valid ? notes[i].amplitude : '0;
                        end
                        r_cnt     <= '0;
                        r_sum     <= '0;
                        r_alloc   <= '0;
                        r_idx     <= '0;
                        r_max_idx <= '0;
                    end
                end
                S_SUM: begin
                    if (r_idx != SUM_DONE) begin
                        r_sum <= r_sum + SW'(r_amp[r_idx]);
                        // Strict compare keeps the lowest index on ties.
                        if (r_amp[r_idx] > r_amp[r_max_idx]) begin
                            r_max_idx <= r_idx;
                        end
                        r_idx <= r_idx + IW'(1);
                    end else begin
                        r_idx <= '0;
                    end
                end
                S_DIV: begin
                    if (w_div_done) begin
                        r_cnt[r_idx] <= w_quot;
                        r_alloc      <= r_alloc + w_quot;
                        if (r_idx != LAST_BIN) begin
                            r_idx       <= r_idx + IW'(1);
                            r_load_pend <= 1'b1;
                        end
                    end
                end
                S_FIXUP: begin
                    LEDCounts <= w_final;
                    data_v    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_count_allocator.sv
// Scoreboard bench for led_count_allocator: stimulus pushes hand-computed frames,
// a negedge monitor pops one entry per data_v pulse and compares counts and timing.
module tb_led_count_allocator;
    import CCHW::*;

    localparam int BIN_QTY  = 12;
    localparam int LEDS     = 50;
    localparam int QW       = $clog2(LEDS);
    localparam int LAT_DIV  = 97;
    localparam int LAT_ZERO = 14;
    localparam int PERIOD   = 98;

    typedef logic [BIN_QTY-1:0][QW-1:0] counts_t;
    typedef struct {
        counts_t counts;
        int      cyc;
        int      total;
    } exp_t;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              start = 1'b0;
    Note [BIN_QTY-1:0] notes;
    counts_t           LEDCounts;
    logic              data_v;
    logic              busy;

    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   mon_tot;
    int   e0;

    // Stimulus tables: amplitudes (1024 = 1.0), valid masks, hand-computed counts.
    int amp_c1[BIN_QTY]  = '{0, 0, 0, 1024, 0, 0, 0, 0, 0, 0, 0, 0};
    int cnt_c1[BIN_QTY]  = '{0, 0, 0, 50, 0, 0, 0, 0, 0, 0, 0, 0};
    int amp_c2[BIN_QTY]  = '{1024, 1024, 1024, 0, 0, 2048, 0, 0, 0, 0, 0, 0};
    int cnt_c2[BIN_QTY]  = '{18, 16, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int amp_c3[BIN_QTY]  = '{3072, 1024, 0, 0, 0, 0, 0, 0, 0, 0, 4000, 0};
    int cnt_c3[BIN_QTY]  = '{38, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int amp_nz[BIN_QTY]  = '{100, 200, 300, 400, 500, 600, 700, 800, 900, 1000, 1100, 1200};
    int amp_0[BIN_QTY]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int cnt_0[BIN_QTY]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    led_count_allocator #(
        .W       (6),
        .D       (10),
        .LEDS    (LEDS),
        .BIN_QTY (BIN_QTY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .notes     (notes),
        .start     (start),
        .LEDCounts (LEDCounts),
        .data_v    (data_v),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic counts_t pack(input int c[BIN_QTY]);
        counts_t r;
        r = '0;
        for (int i = 0; i < BIN_QTY; i++) r[i] = QW'(c[i]);
        return r;
    endfunction

    task automatic set_notes(input int amp[BIN_QTY], input logic [BIN_QTY-1:0] vld);
        for (int i = 0; i < BIN_QTY; i++) begin
            notes[i].amplitude = AMP_W'(amp[i]);
            notes[i].position  = POS_W'(i * 7);
            notes[i].valid     = vld[i];
        end
    endtask

    task automatic push_exp(input counts_t c, input int at_cyc, input int total);
        exp_t e;
        e.counts = c;
        e.cyc    = at_cyc;
        e.total  = total;
        sb.push_back(e);
    endtask

    // Pulse start for one cycle; E0 is the next rising edge.
    task automatic issue(input counts_t c, input int lat, input int total);
        @(negedge clk);
        start = 1'b1;
        push_exp(c, cyc + 1 + lat, total);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
        #1;
        check("frame_completed", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst && data_v) begin
            check("data_v_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                mon_e   = sb.pop_front();
                mon_tot = 0;
                for (int i = 0; i < BIN_QTY; i++) mon_tot += int'(LEDCounts[i]);
                check("led_counts", LEDCounts, mon_e.counts);
                check("count_total", mon_tot, mon_e.total);
                check("data_v_cycle", cyc, mon_e.cyc);
                check("busy_with_data_v", busy, 1'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_notes(amp_0, '0);
        #2 rst = 1'b0;
        #1;
        check("reset_led_counts", LEDCounts, '0);
        check("reset_data_v", data_v, 1'b0);
        check("reset_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Single valid bin takes every LED.
        set_notes(amp_c1, 12'h008);
        issue(pack(cnt_c1), LAT_DIV, 50);
        drain();

        // No valid bins, then valid bins with zero amplitude.
        set_notes(amp_nz, 12'h000);
        issue(pack(cnt_0), LAT_ZERO, 0);
        drain();
        set_notes(amp_0, 12'hFFF);
        issue(pack(cnt_0), LAT_ZERO, 0);
        drain();

        // 3:1 split, with an invalid loud bin that must be ignored.
        set_notes(amp_c3, 12'h003);
        issue(pack(cnt_c3), LAT_DIV, 50);
        drain();

        // Three-way tie: remainder lands on the lowest index.
        set_notes(amp_c2, 12'h007);
        issue(pack(cnt_c2), LAT_DIV, 50);
        drain();

        // Asynchronous reset in the middle of the divide phase.
        set_notes(amp_c2, 12'h007);
        issue(pack(cnt_c2), LAT_DIV, 50);
        repeat (30) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midframe_reset_busy", busy, 1'b0);
        check("midframe_reset_data_v", data_v, 1'b0);
        check("midframe_reset_led_counts", LEDCounts, '0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        issue(pack(cnt_c2), LAT_DIV, 50);
        drain();

        // start held high; notes change after capture and only affect the next frame.
        set_notes(amp_c1, 12'h008);
        @(negedge clk);
        start = 1'b1;
        e0 = cyc + 1;
        push_exp(pack(cnt_c1), e0 + LAT_DIV, 50);
        push_exp(pack(cnt_c3), e0 + PERIOD + LAT_DIV, 50);
        repeat (20) @(negedge clk);
        set_notes(amp_c3, 12'h003);
        for (int k = 0; k < 200 && cyc < e0 + PERIOD; k++) @(negedge clk);
        check("second_capture_busy", busy, 1'b1);
        start = 1'b0;
        drain();
        repeat (110) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/led_count_allocator.md
# led_count_allocator

Converts one frame of per-bin note amplitudes into per-bin LED counts that sum exactly to `LEDS`, for the LED driver's `LEDCounts` input. Sits between the note source (`Note` array) and the LED driver stage. Work is sequential: accumulate, divide per bin, then fix up the remainder. One result frame is published with a single-cycle `data_v` pulse.

## Interface
Parameters:
- `W`, 6, whole bits of the amplitude fixed-point value
- `D`, 10, fractional bits of the amplitude fixed-point value
- `LEDS`, 50, total LEDs. Must not be a power of two; elaboration asserts this.
- `BIN_QTY`, 12, number of note bins

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  one clock; reset is asynchronous and active-low
- `notes`  in  `Note [BIN_QTY-1:0]`  `amplitude` (W+D bits) and `valid` are used; `position` is ignored
- `start`  in  1  level request, sampled only in IDLE
- `LEDCounts`  out  `[BIN_QTY-1:0][$clog2(LEDS)-1:0]`  registered result
- `data_v`  out  1  one-cycle pulse when `LEDCounts` updates
- `busy`  out  1  high in every state except IDLE

## Operation
- Derived widths:
  - QW = $clog2(LEDS)
  - sum width = W+D+$clog2(BIN_QTY)
  - numerator width = W+D+QW
- States: IDLE, SUM, DIV, FIXUP.
- **IDLE**
  - On `start`=1, capture `amp[i] = notes[i].valid ? notes[i].amplitude : 0` for all bins.
  - Clear `sum`, `alloc`, `maxIdx`, and the working counts. Go to SUM.
- **SUM** (BIN_QTY cycles, bin index 0 to BIN_QTY-1)
  - Each cycle: `sum += amp[i]`.
  - Track `maxIdx` as the index of the largest amplitude. Strict `>` compare, so the lowest index wins ties.
  - After the last bin: go to DIV if `sum != 0`, else go to FIXUP.
- **DIV** (per bin, QW+1 cycles)
  - Load `amp[i]*LEDS` and `sum` into the divider, then run QW iterations.
  - Store `cnt[i] = floor(amp[i]*LEDS/sum)` and add it to `alloc`.
  - The quotient is always ≤ LEDS < 2^QW, so no overflow is possible.
- **FIXUP** (1 cycle)
  - If `sum != 0`: `cnt[maxIdx] += LEDS - alloc`.
  - Register `cnt` into `LEDCounts` and set `data_v`=1. Return to IDLE.
- Isolation:
  - `notes` changes after capture do not affect the result.
  - `start` while busy is ignored; no queueing.
- Reset (`rst` low, asynchronous):
  - State returns to IDLE.
  - `LEDCounts`=0, `data_v`=0, `busy`=0, and all internal registers cleared.
  - Reset mid-frame abandons that frame; no `data_v` is produced for it.

## Timing
- `start` sampled high at edge E0 (in IDLE): `data_v` is high for exactly the cycle after edge E0+1+BIN_QTY+BIN_QTY*(QW+1).
  - Defaults: E0+97.
  - `sum`=0 frames: E0+1+BIN_QTY+1 (E0+14).
- `busy` is high from E0+1 until the edge that raises `data_v`, and low in that same cycle.
- With `start` held high, the next frame is captured on the edge where `data_v` falls. Frame period is 98 cycles with defaults.
- `LEDCounts` is stable between `data_v` pulses.

## Structure
- Reuse `CCHW::Note`. Add no new package typedefs.
- Widths are module-local localparams.
- One sub-module, `restoring_divider`:
  - Parameters: numerator width, denominator width, QW.
  - Interface: `load`/`done` handshake, quotient only, same async active-low reset.
- Top-level FSM plus amplitude, count, and accumulator registers make up the rest.

## Test plan
- Only bin 3 valid, amp 1024 (1.0) -> `LEDCounts[3]`=50, all others 0, `data_v` at E0+97.
- Bins 0,1,2 valid, each amp 1024 -> counts 18,16,16, rest 0 (remainder 2 goes to lowest tied index).
- Bin0=3072, bin1=1024 -> 37+1 and 12, i.e. counts 38,12; sum of all counts = 50.
- All `valid`=0, or valid with amp 0 -> all counts 0, `data_v` at E0+14, `busy` falls with it.
- Drive `rst` low mid-DIV -> `busy`, `data_v`, and `LEDCounts` go to 0 immediately without a clock edge. After release, a new `start` yields the correct case-2 result.
- `start` held high; change `notes` 20 cycles into a frame -> the first result reflects the old notes, the second reflects the new notes, and `data_v` pulses are 98 cycles apart.
